// File: rtl/reg_to_obi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_to_obi_bridge                                                          |
// | Register-bus responder that issues one OBI master transaction per          |
// | register-bus request. One transaction in flight at a time. A response      |
// | timeout in the data phase answers with a bus error and drains the late     |
// | rvalid before new requests are accepted.                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

// Register-bus request/response types
package reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

// OBI master request / slave response types
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module reg_to_obi_bridge #(
  parameter type         reg_req_t      = reg_pkg::reg_req_t,
  parameter type         reg_rsp_t      = reg_pkg::reg_rsp_t,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hBADC_AB1E
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  reg_req_t           reg_req_i,
  output reg_rsp_t           reg_rsp_o,
  output obi_pkg::obi_req_t  obi_req_o,
  input  obi_pkg::obi_resp_t obi_resp_i,
  output logic               busy_o,
  output logic               timeout_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_RESP     = 3'd3;
  localparam logic [2:0] S_RESP_ERR = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;

  // A zero TIMEOUT_CYCLES disables the timeout; the counter still needs one bit.
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [2:0]       state_q;
  logic [2:0]       state_d;

  logic [31:0]      addr_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      rdata_q;
  logic             error_q;
  logic [CNT_W-1:0] cnt_q;

  logic             timeout_hit;

  // Timeout fires on the last allowed DATA cycle only when no rvalid arrives;
  // a coincident rvalid completes the transaction normally.
  assign timeout_hit = TIMEOUT_EN
                    && (state_q == S_DATA)
                    && (cnt_q == CNT_LAST)
                    && !obi_resp_i.rvalid;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; rvalid outside DATA/DRAIN is spurious and ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (reg_req_i.valid) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (obi_resp_i.gnt) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (obi_resp_i.rvalid) begin
          state_d = S_RESP;
        end else if (timeout_hit) begin
          state_d = S_RESP_ERR;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_RESP_ERR: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (obi_resp_i.rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; request fields come straight from the
  // captured registers so they stay stable for the whole address phase
  always_comb begin
    obi_req_o       = '0;
    obi_req_o.req   = (state_q == S_ADDR);
    obi_req_o.we    = we_q;
    obi_req_o.be    = be_q;
    obi_req_o.addr  = addr_q;
    obi_req_o.wdata = wdata_q;

    reg_rsp_o       = '0;
    reg_rsp_o.rdata = rdata_q;
    reg_rsp_o.error = error_q;
    reg_rsp_o.ready = (state_q == S_RESP) || (state_q == S_RESP_ERR);

    busy_o          = (state_q != S_IDLE);
    timeout_o       = timeout_hit;
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------

  // Capture the request, run the response counter and latch the response data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (reg_req_i.valid) begin
            addr_q  <= reg_req_i.addr;
            we_q    <= reg_req_i.write;
            wdata_q <= reg_req_i.wdata;
            // Reads fetch the full word regardless of the strobes.
            be_q    <= reg_req_i.write ? reg_req_i.wstrb : 4'hF;
          end
        end
        S_ADDR: begin
          if (obi_resp_i.gnt) begin
            cnt_q <= '0;
          end
        end
        S_DATA: begin
          // Saturating so a disabled or very long timeout never wraps.
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (obi_resp_i.rvalid) begin
            rdata_q <= obi_resp_i.rdata;
            error_q <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= ERR_RDATA;
            error_q <= 1'b1;
          end
        end
        default: begin
          // RESP, RESP_ERR and DRAIN hold everything; late data is discarded.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_to_obi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_to_obi_bridge                                                       |
// | Directed self-checking bench for reg_to_obi_bridge (TIMEOUT_CYCLES = 8).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_reg_to_obi_bridge;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  reg_pkg::reg_req_t  rreq;
  reg_pkg::reg_rsp_t  rrsp;
  obi_pkg::obi_req_t  oreq;
  obi_pkg::obi_resp_t oresp;
  logic               busy;
  logic               tmo;

  int n_tests = 0;
  int n_fail  = 0;

  reg_to_obi_bridge #(
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (ERR)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .reg_req_i  (rreq),
    .reg_rsp_o  (rrsp),
    .obi_req_o  (oreq),
    .obi_resp_i (oresp),
    .busy_o     (busy),
    .timeout_o  (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, expected finish before 50000ns");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1ns after the next rising edge; inputs are driven here.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rq(input logic v, input logic w, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s);
    rreq.valid = v;
    rreq.write = w;
    rreq.addr  = a;
    rreq.wdata = d;
    rreq.wstrb = s;
  endtask

  task automatic ob(input logic g, input logic rv, input logic [31:0] d);
    oresp.gnt    = g;
    oresp.rvalid = rv;
    oresp.rdata  = d;
  endtask

  initial begin
    rq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    ob(1'b0, 1'b0, 32'h0);

    // ---------------- reset state ----------------
    nxt(); nxt(); settle();
    chk("rst_req",   oreq, '0);
    chk("rst_rsp",   rrsp[31:0], 32'h0);
    chk("rst_ready", rrsp.ready, 1'b0);
    chk("rst_error", rrsp.error, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_tmo",   tmo, 1'b0);
    nxt();
    rst_n = 1'b1;

    // ---------------- read, zero-wait slave ----------------
    nxt(); rq(1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'h3); settle();     // t
    chk("rd_idle_busy", busy, 1'b0);
    nxt(); ob(1'b1, 1'b0, 32'h0); settle();                          // t+1
    chk("rd_req",  oreq.req, 1'b1);
    chk("rd_we",   oreq.we, 1'b0);
    chk("rd_be",   oreq.be, 4'hF);
    chk("rd_addr", oreq.addr, 32'h2000_0010);
    nxt(); ob(1'b0, 1'b1, 32'h1234_5678); settle();                  // t+2
    chk("rd_data_req",   oreq.req, 1'b0);
    chk("rd_data_ready", rrsp.ready, 1'b0);
    chk("rd_data_busy",  busy, 1'b1);
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();                          // t+3
    chk("rd_ready", rrsp.ready, 1'b1);
    chk("rd_rdata", rrsp.rdata, 32'h1234_5678);
    chk("rd_error", rrsp.error, 1'b0);
    nxt(); rq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();             // t+4
    chk("rd_after_ready", rrsp.ready, 1'b0);
    chk("rd_after_busy",  busy, 1'b0);
    chk("rd_hold_rdata",  rrsp.rdata, 32'h1234_5678);

    // ---------------- write, gnt delayed 3 cycles ----------------
    nxt(); rq(1'b1, 1'b1, 32'h3000_0004, 32'hAABB_CCDD, 4'b0101); settle();
    for (int i = 0; i < 4; i++) begin                                // t+1..t+4
      nxt(); ob(i == 3, 1'b0, 32'h0); settle();
      chk("wr_req",   oreq.req, 1'b1);
      chk("wr_we",    oreq.we, 1'b1);
      chk("wr_be",    oreq.be, 4'b0101);
      chk("wr_addr",  oreq.addr, 32'h3000_0004);
      chk("wr_wdata", oreq.wdata, 32'hAABB_CCDD);
    end
    nxt(); ob(1'b0, 1'b1, 32'hFEED_F00D); settle();                  // t+5
    chk("wr_data_ready", rrsp.ready, 1'b0);
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();                          // t+6
    chk("wr_ready", rrsp.ready, 1'b1);
    chk("wr_error", rrsp.error, 1'b0);
    chk("wr_rdata", rrsp.rdata, 32'hFEED_F00D);
    nxt(); rq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // ---------------- timeout, drain, held second request ----------------
    nxt(); rq(1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0);               // t
    nxt(); ob(1'b1, 1'b0, 32'h0); settle();                          // g
    chk("to_req", oreq.req, 1'b1);
    for (int k = 1; k <= 8; k++) begin                               // g+1..g+8
      nxt(); ob(1'b0, 1'b0, 32'h0); settle();
      chk("to_pulse", tmo, (k == 8));
      chk("to_wait_ready", rrsp.ready, 1'b0);
    end
    nxt(); settle();                                                 // g+9
    chk("to_ready", rrsp.ready, 1'b1);
    chk("to_error", rrsp.error, 1'b1);
    chk("to_rdata", rrsp.rdata, ERR);
    chk("to_busy",  busy, 1'b1);
    chk("to_no_second_pulse", tmo, 1'b0);
    nxt(); rq(1'b1, 1'b0, 32'h4000_0008, 32'h0, 4'h0); settle();     // g+10
    for (int k = 10; k <= 13; k++) begin
      chk("drain_req",   oreq.req, 1'b0);
      chk("drain_busy",  busy, 1'b1);
      chk("drain_ready", rrsp.ready, 1'b0);
      chk("drain_tmo",   tmo, 1'b0);
      nxt(); settle();
    end
    ob(1'b0, 1'b1, 32'hDEAD_0000); settle();                         // g+14
    chk("drain_rv_req", oreq.req, 1'b0);
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();                          // g+15
    chk("drain_done_busy",  busy, 1'b0);
    chk("drain_done_req",   oreq.req, 1'b0);
    chk("drain_done_ready", rrsp.ready, 1'b0);
    chk("drain_discard",    rrsp.rdata, ERR);
    nxt(); ob(1'b1, 1'b0, 32'h0); settle();                          // g+16
    chk("second_req",  oreq.req, 1'b1);
    chk("second_addr", oreq.addr, 32'h4000_0008);
    nxt(); ob(1'b0, 1'b1, 32'h5555_AAAA); settle();
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();
    chk("second_ready", rrsp.ready, 1'b1);
    chk("second_error", rrsp.error, 1'b0);
    chk("second_rdata", rrsp.rdata, 32'h5555_AAAA);
    nxt(); rq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // ---------------- rvalid exactly in the timeout cycle ----------------
    nxt(); rq(1'b1, 1'b0, 32'h4000_0100, 32'h0, 4'h0);
    nxt(); ob(1'b1, 1'b0, 32'h0);                                    // g
    for (int k = 1; k <= 7; k++) begin
      nxt(); ob(1'b0, 1'b0, 32'h0);
    end
    nxt(); ob(1'b0, 1'b1, 32'h7777_8888); settle();                  // g+8
    chk("edge_tmo", tmo, 1'b0);
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();                          // g+9
    chk("edge_ready", rrsp.ready, 1'b1);
    chk("edge_error", rrsp.error, 1'b0);
    chk("edge_rdata", rrsp.rdata, 32'h7777_8888);
    nxt(); rq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();             // g+10
    chk("edge_no_drain", busy, 1'b0);

    // ---------------- back-to-back reads, valid held ----------------
    nxt(); rq(1'b1, 1'b0, 32'h6000_0000, 32'h0, 4'h0);               // t
    nxt(); ob(1'b1, 1'b0, 32'h0); settle();                          // t+1
    chk("b2b_req1_addr", oreq.addr, 32'h6000_0000);
    nxt(); ob(1'b0, 1'b1, 32'h1111_1111);                            // t+2
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();                          // t+3
    chk("b2b_ready1", rrsp.ready, 1'b1);
    chk("b2b_rdata1", rrsp.rdata, 32'h1111_1111);
    nxt(); rq(1'b1, 1'b0, 32'h6000_0004, 32'h0, 4'h0); settle();     // t+4 (IDLE)
    chk("b2b_gap_req",   oreq.req, 1'b0);
    chk("b2b_gap_ready", rrsp.ready, 1'b0);
    nxt(); ob(1'b1, 1'b0, 32'h0); settle();                          // t+5
    chk("b2b_req2",      oreq.req, 1'b1);
    chk("b2b_req2_addr", oreq.addr, 32'h6000_0004);
    nxt(); ob(1'b0, 1'b1, 32'h2222_2222);
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();
    chk("b2b_ready2", rrsp.ready, 1'b1);
    chk("b2b_rdata2", rrsp.rdata, 32'h2222_2222);
    nxt(); rq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // ---------------- asynchronous reset mid-DATA ----------------
    nxt(); rq(1'b1, 1'b0, 32'h7000_0000, 32'h0, 4'h0);
    nxt(); ob(1'b1, 1'b0, 32'h0);                                    // ADDR
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();                          // DATA
    chk("ar_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    rq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    chk("ar_req",   oreq.req, 1'b0);
    chk("ar_ready", rrsp.ready, 1'b0);
    chk("ar_busy",  busy, 1'b0);
    chk("ar_rdata", rrsp.rdata, 32'h0);
    nxt(); nxt();
    rst_n = 1'b1;
    ob(1'b0, 1'b1, 32'hCAFE_CAFE);                                   // stale rvalid
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();
    chk("ar_stale_ready", rrsp.ready, 1'b0);
    chk("ar_stale_busy",  busy, 1'b0);
    chk("ar_stale_rdata", rrsp.rdata, 32'h0);
    nxt(); rq(1'b1, 1'b0, 32'h5000_0000, 32'h0, 4'h0);
    nxt(); ob(1'b1, 1'b0, 32'h0); settle();
    chk("ar_new_req", oreq.req, 1'b1);
    nxt(); ob(1'b0, 1'b1, 32'h1357_9BDF);
    nxt(); ob(1'b0, 1'b0, 32'h0); settle();
    chk("ar_new_ready", rrsp.ready, 1'b1);
    chk("ar_new_rdata", rrsp.rdata, 32'h1357_9BDF);
    chk("ar_new_error", rrsp.error, 1'b0);
    nxt(); rq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); settle();
    chk("ar_new_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
